// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the 4-point FFT datapath
//   DEFAULT_WIDTH : default component width of complex samples
//   FRAME_LEN     : bins per frame
//   state_t       : frame sequencing states COLLECT/STAGE1/STAGE2/EMIT
package fft_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int FRAME_LEN     = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    STAGE1  = 2'd1,
    STAGE2  = 2'd2,
    EMIT    = 2'd3
  } state_t;

endpackage

// File: rtl/ifft_butterfly_scaled.sv
// rtl/ifft_butterfly_scaled.sv - combinational complex add/sub butterfly with optional j rotation and /2 scaling
//   a_re/a_im     : first operand
//   b_re/b_im     : second operand
//   rot           : 1 = replace b by j*b before add/sub
//   sum_re/sum_im : scaled a + b'
//   diff_re/diff_im : scaled a - b'
module ifft_butterfly_scaled #(
  parameter int WIDTH = 16,
  parameter int SCALE = 1
) (
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic             rot,
  output logic [WIDTH-1:0] sum_re,
  output logic [WIDTH-1:0] sum_im,
  output logic [WIDTH-1:0] diff_re,
  output logic [WIDTH-1:0] diff_im
);

  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] bi;
  logic [WIDTH:0]   s_re;
  logic [WIDTH:0]   s_im;
  logic [WIDTH:0]   d_re;
  logic [WIDTH:0]   d_im;

  // j*(r,i) = (-i,r); negating the most negative value wraps on purpose.
  always_comb begin
    br = b_re;
    bi = b_im;
    if (rot) begin
      br = -b_im;
      bi = b_re;
    end
  end

  // One guard bit so the sum never overflows before the optional halving.
  assign s_re = {a_re[WIDTH-1], a_re} + {br[WIDTH-1], br};
  assign s_im = {a_im[WIDTH-1], a_im} + {bi[WIDTH-1], bi};
  assign d_re = {a_re[WIDTH-1], a_re} - {br[WIDTH-1], br};
  assign d_im = {a_im[WIDTH-1], a_im} - {bi[WIDTH-1], bi};

  // Dropping the LSB of the extended value is an arithmetic shift (floor).
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH:0] v);
    return (SCALE != 0) ? v[WIDTH:1] : v[WIDTH-1:0];
  endfunction

  assign sum_re  = scale(s_re);
  assign sum_im  = scale(s_im);
  assign diff_re = scale(d_re);
  assign diff_im = scale(d_im);

endmodule

// File: rtl/ifft_4point_stream.sv
// rtl/ifft_4point_stream.sv - serial-in/serial-out 4-point radix-2 inverse FFT with per-stage 1/2 scaling
//   clk, reset (async active-low)
//   in_valid/in_ready/in_re/in_im : bin stream X0..X3
//   out_valid/out_ready/out_re/out_im/out_idx/out_last : sample stream x0..x3
//   busy : high outside COLLECT
module ifft_4point_stream
  import fft_pkg::*;
#(
  parameter int WIDTH = fft_pkg::DEFAULT_WIDTH,
  parameter int SCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [1:0]       in_cnt_q, in_cnt_d;
  logic [1:0]       out_idx_q, out_idx_d;
  logic [WIDTH-1:0] x_re_q [4];
  logic [WIDTH-1:0] x_im_q [4];
  logic [WIDTH-1:0] a_re_q [4];
  logic [WIDTH-1:0] a_im_q [4];
  logic [WIDTH-1:0] y_re_q [4];
  logic [WIDTH-1:0] y_im_q [4];
  logic [WIDTH-1:0] x_re_d [4];
  logic [WIDTH-1:0] x_im_d [4];
  logic [WIDTH-1:0] a_re_d [4];
  logic [WIDTH-1:0] a_im_d [4];
  logic [WIDTH-1:0] y_re_d [4];
  logic [WIDTH-1:0] y_im_d [4];

  // Stage results: s1 index = a0..a3, s2 index = y0..y3
  logic [WIDTH-1:0] s1_re [4];
  logic [WIDTH-1:0] s1_im [4];
  logic [WIDTH-1:0] s2_re [4];
  logic [WIDTH-1:0] s2_im [4];

  ifft_butterfly_scaled #(.WIDTH(WIDTH), .SCALE(SCALE)) u_bf1_even (
    .a_re(x_re_q[0]), .a_im(x_im_q[0]), .b_re(x_re_q[2]), .b_im(x_im_q[2]), .rot(1'b0),
    .sum_re(s1_re[0]), .sum_im(s1_im[0]), .diff_re(s1_re[1]), .diff_im(s1_im[1])
  );

  ifft_butterfly_scaled #(.WIDTH(WIDTH), .SCALE(SCALE)) u_bf1_odd (
    .a_re(x_re_q[1]), .a_im(x_im_q[1]), .b_re(x_re_q[3]), .b_im(x_im_q[3]), .rot(1'b0),
    .sum_re(s1_re[2]), .sum_im(s1_im[2]), .diff_re(s1_re[3]), .diff_im(s1_im[3])
  );

  // y0 = a0+a2, y2 = a0-a2
  ifft_butterfly_scaled #(.WIDTH(WIDTH), .SCALE(SCALE)) u_bf2_even (
    .a_re(a_re_q[0]), .a_im(a_im_q[0]), .b_re(a_re_q[2]), .b_im(a_im_q[2]), .rot(1'b0),
    .sum_re(s2_re[0]), .sum_im(s2_im[0]), .diff_re(s2_re[2]), .diff_im(s2_im[2])
  );

  // y1 = a1+j*a3, y3 = a1-j*a3 (inverse transform uses the +j twiddle)
  ifft_butterfly_scaled #(.WIDTH(WIDTH), .SCALE(SCALE)) u_bf2_odd (
    .a_re(a_re_q[1]), .a_im(a_im_q[1]), .b_re(a_re_q[3]), .b_im(a_im_q[3]), .rot(1'b1),
    .sum_re(s2_re[1]), .sum_im(s2_im[1]), .diff_re(s2_re[3]), .diff_im(s2_im[3])
  );

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_idx_d = out_idx_q;
    x_re_d    = x_re_q;
    x_im_d    = x_im_q;
    a_re_d    = a_re_q;
    a_im_d    = a_im_q;
    y_re_d    = y_re_q;
    y_im_d    = y_im_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          x_re_d[in_cnt_q] = in_re;
          x_im_d[in_cnt_q] = in_im;
          in_cnt_d         = in_cnt_q + 2'd1;
          if (in_cnt_q == 2'(FRAME_LEN - 1)) state_d = STAGE1;
        end
      end
      STAGE1: begin
        a_re_d  = s1_re;
        a_im_d  = s1_im;
        state_d = STAGE2;
      end
      STAGE2: begin
        y_re_d    = s2_re;
        y_im_d    = s2_im;
        out_idx_d = 2'd0;
        state_d   = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'(FRAME_LEN - 1)) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= COLLECT;
      in_cnt_q  <= 2'd0;
      out_idx_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        x_re_q[i] <= '0;
        x_im_q[i] <= '0;
        a_re_q[i] <= '0;
        a_im_q[i] <= '0;
        y_re_q[i] <= '0;
        y_im_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_idx_q <= out_idx_d;
      x_re_q    <= x_re_d;
      x_im_q    <= x_im_d;
      a_re_q    <= a_re_d;
      a_im_q    <= a_im_d;
      y_re_q    <= y_re_d;
      y_im_q    <= y_im_d;
    end
  end

  // All outputs decode directly from flops, so the async reset clears them at once.
  assign in_ready  = (state_q == COLLECT);
  assign busy      = (state_q != COLLECT);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = out_idx_q;
  assign out_last  = out_valid && (out_idx_q == 2'(FRAME_LEN - 1));
  assign out_re    = out_valid ? y_re_q[out_idx_q] : '0;
  assign out_im    = out_valid ? y_im_q[out_idx_q] : '0;

endmodule
